// File: rtl/step_select_ctrl.sv
// Manual/auto step controller: debounces the mode and step buttons and drives the display mux select and register enable.
// Optional build macro STEP_COUNT_EN adds an 8-bit step_count output that counts reg_en pulses.
module step_select_ctrl #(
  parameter int DIV_COUNT       = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       step_btn,
  output logic       select,
  output logic       reg_en,
  output logic       tick_out,
  output logic       mode_led
`ifdef STEP_COUNT_EN
  ,
  output logic [7:0] step_count
`endif
);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  localparam int MODE = 0;
  localparam int STEP = 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV_COUNT - 1);

  logic [1:0]       btn_raw;
  logic [1:0]       sync1, sync2;
  logic [1:0]       db, db_q;
  logic [1:0]       press_evt;
  logic [CNT_W-1:0] db_cnt [2];
  logic [CNT_W-1:0] tick_cnt;

  state_t state, state_nx;
  logic   reg_en_nx;

  assign btn_raw = {step_btn, mode_btn};

  // Two-flop synchronizer, debounce and registered rising-edge detect per button.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      db_q      <= '0;
      press_evt <= '0;
      // NOTE: the debounce counters are only two entries, so they are reset explicitly like plain flops.
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      db_q      <= db;
      press_evt <= db & ~db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Auto tick divider: idles at zero outside AUTO, so AUTO entry always starts a full period.
  always_ff @(posedge clk) begin
    if (reset || state != AUTO) begin
      tick_cnt <= '0;
      tick_out <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      tick_out <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick_out <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    state_nx  = state;
    reg_en_nx = 1'b0;
    case (state)
      MANUAL: begin
        reg_en_nx = press_evt[STEP];
        if (press_evt[MODE]) state_nx = AUTO;
      end
      AUTO: begin
        reg_en_nx = tick_out;
        if (press_evt[MODE]) state_nx = MANUAL;
      end
      default: state_nx = MANUAL;
    endcase
    // A step arriving right after a mode-change tick would otherwise give back-to-back enables.
    if (reg_en) reg_en_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MANUAL;
      reg_en <= 1'b0;
    end else begin
      state  <= state_nx;
      reg_en <= reg_en_nx;
    end
  end

  assign select   = (state == AUTO);
  assign mode_led = (state == AUTO);

`ifdef STEP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)       step_count <= '0;
    else if (reg_en) step_count <= step_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_step_select_ctrl.sv
// Directed bench for step_select_ctrl with DIV_COUNT=4, DEBOUNCE_CYCLES=3; cycle k is the state after the k-th edge.
// Inputs are driven and outputs sampled on the falling edge.
module tb_step_select_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic reset;
  logic mode_btn;
  logic step_btn;
  logic select;
  logic reg_en;
  logic tick_out;
  logic mode_led;
`ifdef STEP_COUNT_EN
  logic [7:0] step_count;
`endif

  int checks = 0;
  int errors = 0;

  step_select_ctrl #(
    .DIV_COUNT      (DIV),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (26)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .step_btn  (step_btn),
    .select    (select),
    .reg_en    (reg_en),
    .tick_out  (tick_out),
    .mode_led  (mode_led)
`ifdef STEP_COUNT_EN
    ,
    .step_count(step_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;

    reset    = 1'b1;
    mode_btn = 1'b0;
    step_btn = 1'b0;
    cyc(3);
    check("rst_select",   32'(select),   32'(0));
    check("rst_reg_en",   32'(reg_en),   32'(0));
    check("rst_tick_out", 32'(tick_out), 32'(0));
    check("rst_mode_led", 32'(mode_led), 32'(0));
    reset = 1'b0;

    // Held step button: one enable, 7 cycles after the rise.
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("step_reg_en_k%0d", k), 32'(reg_en), 32'(k == 7));
      check($sformatf("step_select_k%0d", k), 32'(select), 32'(0));
    end
    step_btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("release_reg_en_k%0d", k), 32'(reg_en), 32'(0));
    end

    // Two-cycle glitch never reaches the debounced level.
    step_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("glitch_reg_en_k%0d", k), 32'(reg_en), 32'(0));
      check($sformatf("glitch_db_k%0d", k), 32'(dut.db[1]), 32'(0));
    end

    // Reset asserted while the press event is pending suppresses the enable.
    step_btn = 1'b1;
    cyc(6);
    reset    = 1'b1;
    step_btn = 1'b0;
    cyc();
    check("reset_kills_reg_en", 32'(reg_en), 32'(0));
    cyc(2);
    reset = 1'b0;

    // Mode press enters AUTO at k=7; ticks at 11,15,19; enables one cycle later; step ignored.
    mode_btn = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      if (k == 8)  step_btn = 1'b1;
      if (k == 10) mode_btn = 1'b0;
      if (k == 18) step_btn = 1'b0;
      cyc();
      check($sformatf("auto_select_k%0d", k),   32'(select),   32'(k >= 7));
      check($sformatf("auto_mode_led_k%0d", k), 32'(mode_led), 32'(k >= 7));
      check($sformatf("auto_tick_k%0d", k),     32'(tick_out), 32'(k >= 11 && (k - 11) % 4 == 0));
      check($sformatf("auto_reg_en_k%0d", k),   32'(reg_en),   32'(k >= 12 && (k - 12) % 4 == 0));
    end

    // Align a mode press event with a tick: the tick is honored, then back to MANUAL.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc();
      if (tick_out) found = 1'b1;
    end
    check("tick_wait", 32'(found), 32'(1));
    cyc(2);
    mode_btn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 10) mode_btn = 1'b0;
      cyc();
      check($sformatf("align_tick_k%0d", k),   32'(tick_out), 32'(k == 2 || k == 6));
      check($sformatf("align_reg_en_k%0d", k), 32'(reg_en),   32'(k == 3 || k == 7));
      check($sformatf("align_select_k%0d", k), 32'(select),   32'(k < 7));
    end

    // Reset in AUTO with the tick counter at 2.
    cyc(6);
    mode_btn = 1'b1;
    cyc(9);
    check("pre_reset_select",   32'(select),       32'(1));
    check("pre_reset_tick_cnt", 32'(dut.tick_cnt), 32'(2));
    reset    = 1'b1;
    mode_btn = 1'b0;
    cyc();
    check("auto_rst_select",   32'(select),       32'(0));
    check("auto_rst_mode_led", 32'(mode_led),     32'(0));
    check("auto_rst_reg_en",   32'(reg_en),       32'(0));
    check("auto_rst_tick_out", 32'(tick_out),     32'(0));
    check("auto_rst_tick_cnt", 32'(dut.tick_cnt), 32'(0));
    cyc(2);
    reset = 1'b0;

`ifdef STEP_COUNT_EN
    check("step_count_rst", 32'(step_count), 32'(0));
    for (int n = 0; n < 257; n++) begin
      step_btn = 1'b1;
      cyc(8);
      step_btn = 1'b0;
      cyc(8);
      if (n == 0) check("step_count_first", 32'(step_count), 32'(1));
    end
    check("step_count_wrap", 32'(step_count), 32'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_select_ctrl.md
Name: step_select_ctrl

Overview:
- Mode controller that drives the select line of the display's 2-to-1 register-enable multiplexer.
- Chooses between manual stepping (debounced step button) and automatic stepping (internal divided tick).
- Generates the single-cycle register enable for the display value register.
- Sits between the board buttons and the display register; replaces ad-hoc select wiring with a synchronized, debounced state machine.

Parameters:
- DIV_COUNT, 50000000, clk cycles per auto tick (>=2); tick period in AUTO.
- DEBOUNCE_CYCLES, 1000000, consecutive identical synchronized samples required to accept a button level change (>=2).
- CNT_W, 26, width of the tick and debounce counters; must hold max(DIV_COUNT, DEBOUNCE_CYCLES)-1.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- mode_btn  input  1  raw asynchronous mode button; a press toggles MANUAL/AUTO.
- step_btn  input  1  raw asynchronous step button; a press requests one step in MANUAL.
- select  output  1  mux select: 0 = manual step path (in0), 1 = auto tick path (in1).
- reg_en  output  1  registered one-cycle enable pulse to the display register.
- tick_out  output  1  raw auto tick pulse, routed to the mux in1 path.
- mode_led  output  1  high in AUTO.

Behaviour:
- Reset (synchronous, active-high): FSM=MANUAL; select=0, reg_en=0, tick_out=0, mode_led=0; all counters=0; synchronizer and debounced levels=0. Reset mid-pulse kills reg_en on the next edge.
- Synchronizer: two-flop chain per button; output s.
- Debounce, per button, register db:
  - If s==db: counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1: db<=s, counter<=0.
  - Else: counter++.
  - db therefore changes only after DEBOUNCE_CYCLES consecutive mismatched samples; a glitch shorter than that never changes db.
- Press event: db & ~db_q, where db_q is db delayed one cycle. Exactly one cycle per accepted press; release generates nothing.
- Tick counter:
  - Runs only in AUTO; held at 0 in MANUAL.
  - Cleared to 0 on the cycle AUTO is entered.
  - tick_out=1 when counter==DIV_COUNT-1; counter then wraps to 0.
  - First tick comes DIV_COUNT cycles after entering AUTO.
- FSM states: MANUAL, AUTO.
  - MANUAL: mode press -> AUTO. Step press -> reg_en=1 next cycle.
  - AUTO: mode press -> MANUAL. tick_out -> reg_en=1 next cycle. Step press is ignored.
- Outputs:
  - select and mode_led are registered and equal (FSM==AUTO).
  - reg_en is registered and is never high for two consecutive cycles.
- Simultaneous events:
  - MANUAL, step press and mode press in the same cycle: the step is honored (reg_en next cycle) and the FSM moves to AUTO.
  - AUTO, tick and mode press in the same cycle: the tick is honored (reg_en next cycle) and the FSM moves to MANUAL.
  - Both buttons pressed constantly: each accepted edge is processed independently.
- Latency:
  - Button stable high from cycle 0 -> press event at cycle 2+DEBOUNCE_CYCLES+1.
  - reg_en (MANUAL step) one cycle after the press event.

Optional Feature:
- STEP_COUNT_EN defined: adds output step_count, 8 bits.
  - Increments on every cycle reg_en=1.
  - Wraps 255 -> 0.
  - Reset to 0.
  - Not cleared by mode changes.
- STEP_COUNT_EN undefined: step_count port and its logic are absent; all other behaviour is identical.

Test Plan (DIV_COUNT=4, DEBOUNCE_CYCLES=3):
- Reset, then step_btn held high 10 cycles -> exactly one reg_en pulse, at cycle 7 after the rise (2 sync + 3 debounce + edge + 1 register); select=0 throughout.
- step_btn high for 2 cycles then low (glitch) -> no reg_en; db stays 0.
- mode_btn press -> select=1 and mode_led=1; reg_en pulses every 4 cycles, first pulse 5 cycles after AUTO entry; step_btn presses are ignored.
- In AUTO, align a mode press with a tick -> one reg_en for that tick, then select=0 and no further pulses.
- Assert reset during AUTO with the tick counter at 2 -> next cycle select=0, reg_en=0, tick counter=0.
- With STEP_COUNT_EN: issue 257 steps -> step_count=1.
